// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: score, serve timing, ball/paddle run control.
// Keys are edge-detected; the start key must be seen released after reset.
module pong_match_ctrl #(
    parameter logic [1:0] WIN_SCORE    = 2'd3,
    parameter logic [7:0] SERVE_FRAMES = 8'd60,
    parameter logic [7:0] POINT_FRAMES = 8'd30
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       frame_tick,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_serve,
    output logic       serve_dir,
    output logic       paddle_en,
    output logic [3:0] score,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic [2:0] state_q, state_d;
    logic [1:0] left_q, left_d;
    logic [1:0] right_q, right_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       win_q, win_d;
    logic       serve_q, serve_d;
    logic       start_q, pause_q, arm_q;

    logic       start_rise, pause_rise;
    logic [1:0] left_inc, right_inc;

    // A key held through reset must be released before it can start a match.
    assign start_rise = start_key & ~start_q & arm_q;
    assign pause_rise = pause_key & ~pause_q;
    assign left_inc   = left_q + 2'd1;
    assign right_inc  = right_q + 2'd1;

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        win_d   = win_q;
        serve_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    left_d  = 2'd0;
                    right_d = 2'd0;
                    dir_d   = 1'b0;
                    serve_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == SERVE_FRAMES - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (start_rise) begin
                    left_d  = 2'd0;
                    right_d = 2'd0;
                    dir_d   = 1'b0;
                    serve_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_SERVE;
                end else if (miss_left && miss_right) begin
                    serve_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_SERVE;
                end else if (miss_left) begin
                    right_d = right_inc;
                    dir_d   = 1'b0;
                    cnt_d   = 8'd0;
                    if (right_inc == WIN_SCORE) begin
                        win_d   = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        state_d = S_POINT;
                    end
                end else if (miss_right) begin
                    left_d = left_inc;
                    dir_d  = 1'b1;
                    cnt_d  = 8'd0;
                    if (left_inc == WIN_SCORE) begin
                        win_d   = 1'b0;
                        state_d = S_OVER;
                    end else begin
                        state_d = S_POINT;
                    end
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == POINT_FRAMES - 8'd1) begin
                        serve_d = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_SERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PAUSE: begin
                if (start_rise) begin
                    left_d  = 2'd0;
                    right_d = 2'd0;
                    dir_d   = 1'b0;
                    serve_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_SERVE;
                end else if (pause_rise) begin
                    state_d = S_PLAY;
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    left_d  = 2'd0;
                    right_d = 2'd0;
                    dir_d   = 1'b0;
                    serve_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_SERVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            left_q  <= 2'd0;
            right_q <= 2'd0;
            cnt_q   <= 8'd0;
            dir_q   <= 1'b0;
            win_q   <= 1'b0;
            serve_q <= 1'b0;
            start_q <= 1'b0;
            pause_q <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            win_q   <= win_d;
            serve_q <= serve_d;
            start_q <= start_key;
            pause_q <= pause_key;
            arm_q   <= arm_q | ~start_key;
        end
    end

    assign ball_run   = (state_q == S_PLAY);
    assign paddle_en  = (state_q == S_SERVE) || (state_q == S_PLAY);
    assign game_over  = (state_q == S_OVER);
    assign ball_serve = serve_q;
    assign serve_dir  = dir_q;
    assign winner     = win_q;
    assign score      = {left_q, right_q};
    assign state_dbg  = state_q;

endmodule
